// File: rtl/level_3_gen_pkg.sv
// level_pkg: shared types and constants for the level_3_gen merge stage
// and the merge_sel selector.
//   state_t    : merge FSM states (2-bit encoding)
//   GROUP_IN   : elements per sorted input group
//   GROUP_OUT  : elements per merged output vector
//   CNT_W      : width of the output element counter
//   SRC_CNT_W  : width of the per-group consumed-element counters (0..GROUP_IN)
package level_pkg;

  localparam int unsigned GROUP_IN  = 4;
  localparam int unsigned GROUP_OUT = 8;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned SRC_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT2 = 2'd1,
    MERGE = 2'd2
  } state_t;

endpackage

// File: rtl/level_3_gen_merge_sel.sv
// merge_sel: combinational two-way merge selector.
// Picks the larger of the two group heads, honouring exhaustion counts.
// Ties go to B so ordering matches the upstream level.
//   head_a, head_b : current top elements of groups A and B
//   cnt_a, cnt_b   : elements already consumed from each group
//   sel_a          : 1 when A supplies this output element
//   sel_data       : the selected element
module merge_sel
  import level_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] head_a,
  input  logic [DATA_WIDTH-1:0] head_b,
  input  logic [SRC_CNT_W-1:0]  cnt_a,
  input  logic [SRC_CNT_W-1:0]  cnt_b,
  output logic                  sel_a,
  output logic [DATA_WIDTH-1:0] sel_data
);

  localparam logic [SRC_CNT_W-1:0] FULL = SRC_CNT_W'(GROUP_IN);

  logic a_left;
  logic b_done;

  always_comb begin
    a_left   = (cnt_a < FULL);
    b_done   = (cnt_b == FULL);
    // Exhaustion is tracked by count, never by value: 0 is a legal element.
    sel_a    = a_left && (b_done || (head_a > head_b));
    sel_data = sel_a ? head_a : head_b;
  end

endmodule

// File: rtl/level_3_gen.sv
// level_3_gen: merges two consecutive descending-sorted 4-element groups
// into one descending-sorted 8-element vector, one element per cycle.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   idata  : sorted group, largest element in the MSB slice
//   ivalid : idata valid this cycle
//   iready : high when a group can be accepted (IDLE or WAIT2)
//   odata  : merged result, largest element in the MSB slice
//   ovalid : one-cycle pulse when odata is complete
module level_3_gen
  import level_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [GROUP_IN*DATA_WIDTH-1:0]  idata,
  input  logic                            ivalid,
  output logic                            iready,
  output logic [GROUP_OUT*DATA_WIDTH-1:0] odata,
  output logic                            ovalid
);

  localparam int unsigned IN_W  = GROUP_IN * DATA_WIDTH;
  localparam int unsigned OUT_W = GROUP_OUT * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUP_OUT - 1);

  state_t                state;
  logic [IN_W-1:0]       buf_a;
  logic [IN_W-1:0]       buf_b;
  logic [SRC_CNT_W-1:0]  cnt_a;
  logic [SRC_CNT_W-1:0]  cnt_b;
  logic [CNT_W-1:0]      cnt;
  logic                  sel_a;
  logic [DATA_WIDTH-1:0] sel_data;

  merge_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_merge_sel (
    .head_a  (buf_a[IN_W-1 -: DATA_WIDTH]),
    .head_b  (buf_b[IN_W-1 -: DATA_WIDTH]),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .sel_a   (sel_a),
    .sel_data(sel_data)
  );

  assign iready = (state != MERGE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      buf_a  <= '0;
      buf_b  <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      cnt    <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
    end else begin
      ovalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ivalid) begin
            buf_a <= idata;
            state <= WAIT2;
          end
        end
        WAIT2: begin
          if (ivalid) begin
            buf_b <= idata;
            cnt   <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            state <= MERGE;
          end
        end
        MERGE: begin
          // Shift the winner in at the LSB so the first (largest) pick ends up in the MSB slice.
          odata <= {odata[OUT_W-DATA_WIDTH-1:0], sel_data};
          if (sel_a) begin
            buf_a <= {buf_a[IN_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
            cnt_a <= cnt_a + 1'b1;
          end else begin
            buf_b <= {buf_b[IN_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
            cnt_b <= cnt_b + 1'b1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            ovalid <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_3_gen.sv
// tb_level_3_gen: directed self-checking bench for level_3_gen.
module tb_level_3_gen;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [31:0]   idata;
  logic          ivalid;
  logic          iready;
  logic [63:0]   odata;
  logic          ovalid;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned pulses;

  level_3_gen #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .idata (idata),
    .ivalid(ivalid),
    .iready(iready),
    .odata (odata),
    .ovalid(ovalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ovalid) pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] g4(input logic [7:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  // Called at a negedge; ends at the negedge of the ovalid cycle.
  // sel_exp[7] is the expected pick for the first merge cycle (1 = A).
  task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input logic [7:0] sel_exp,
                          input bit drop_mid);
    idata  = a;
    ivalid = 1'b1;
    @(negedge clk);
    check({tag, "_wait2_ready"}, 64'(iready), 64'd1);
    idata = b;
    @(negedge clk);
    ivalid = 1'b0;
    idata  = '0;
    check({tag, "_merge_busy"}, 64'(iready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_sel%0d", tag, i), 64'(dut.sel_a), 64'(sel_exp[7-i]));
      check($sformatf("%s_noval%0d", tag, i), 64'(ovalid), 64'd0);
      if (drop_mid && i == 3) begin
        ivalid = 1'b1;
        idata  = g4(8'd99, 8'd99, 8'd99, 8'd99);
      end else begin
        ivalid = 1'b0;
        idata  = '0;
      end
      @(negedge clk);
    end
    ivalid = 1'b0;
    check({tag, "_ovalid"}, 64'(ovalid), 64'd1);
    check({tag, "_odata"}, odata, exp);
    check({tag, "_ready"}, 64'(iready), 64'd1);
  endtask

  task automatic hold_check(input string tag, input logic [63:0] exp);
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'(ovalid), 64'd0);
    check({tag, "_hold"}, odata, exp);
  endtask

  localparam logic [63:0] R1 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1};
  localparam logic [63:0] R2 = {8'd5, 8'd5, 8'd5, 8'd4, 8'd3, 8'd3, 8'd3, 8'd0};
  localparam logic [63:0] R3 = {8'd200, 8'd190, 8'd180, 8'd170, 8'd10, 8'd9, 8'd0, 8'd0};
  localparam logic [63:0] R5 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

  int unsigned p0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pulses  = 0;
    rst     = 1'b1;
    ivalid  = 1'b0;
    idata   = '0;
    #2;
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_odata", odata, 64'd0);
    check("rst_ready", 64'(iready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic merge
    run_pair("c1", g4(9, 7, 4, 1), g4(8, 6, 5, 2), R1, 8'hA5, 1'b0);
    hold_check("c1", R1);
    // 2: ties go to B
    run_pair("c2", g4(5, 5, 3, 3), g4(5, 4, 3, 0), R2, 8'h66, 1'b0);
    hold_check("c2", R2);
    // 3: exhaustion with zero elements
    run_pair("c3", g4(200, 190, 180, 170), g4(10, 9, 0, 0), R3, 8'hF0, 1'b0);
    hold_check("c3", R3);
    run_pair("c3z", '0, '0, 64'd0, 8'h0F, 1'b0);
    hold_check("c3z", 64'd0);
    // 4: ivalid during MERGE dropped
    run_pair("c4", g4(9, 7, 4, 1), g4(8, 6, 5, 2), R1, 8'hA5, 1'b1);
    hold_check("c4", R1);
    run_pair("c4n", g4(5, 5, 3, 3), g4(5, 4, 3, 0), R2, 8'h66, 1'b0);
    hold_check("c4n", R2);

    // 5: reset at merge cycle 4
    p0 = pulses;
    idata  = g4(9, 7, 4, 1);
    ivalid = 1'b1;
    @(negedge clk);
    idata = g4(8, 6, 5, 2);
    @(negedge clk);
    ivalid = 1'b0;
    idata  = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("c5_rst_ovalid", 64'(ovalid), 64'd0);
    check("c5_rst_odata", odata, 64'd0);
    check("c5_rst_ready", 64'(iready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("c5_no_pulse", 64'(pulses - p0), 64'd0);
    check("c5_odata_clear", odata, 64'd0);
    run_pair("c5", g4(4, 3, 2, 1), g4(8, 7, 6, 5), R5, 8'h0F, 1'b0);
    hold_check("c5", R5);

    // 6: back-to-back, new first group on the ovalid cycle
    p0 = pulses;
    run_pair("c6a", g4(9, 7, 4, 1), g4(8, 6, 5, 2), R1, 8'hA5, 1'b0);
    run_pair("c6b", g4(5, 5, 3, 3), g4(5, 4, 3, 0), R2, 8'h66, 1'b0);
    hold_check("c6b", R2);
    repeat (3) @(negedge clk);
    check("c6_pulses", 64'(pulses - p0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
